// File: rtl/core_pkg.sv
// +------------------------------------------------------------------+
// | core_pkg : shared types and constants for the front-end buffers   |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

package core_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_WIDTH    = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]    pc;
   } fq_entry_t;

   // Number of set bits among two valid flags, as a 0/1/2 increment.
   function automatic logic [1:0] pop_count(input logic a, input logic b);
      return {a & b, a ^ b};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
// +------------------------------------------------------------------+
// | fetch_queue_if : fetch-side push and decoder-side pop bundle      |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

interface fetch_queue_if #(
   parameter int INSTR_WIDTH = 32,
   parameter int PC_WIDTH    = 32,
   parameter int DEPTH       = 8
);
   logic                     flush_i;
   logic                     push1_valid_i;
   logic [INSTR_WIDTH-1:0]   push1_instr_i;
   logic [PC_WIDTH-1:0]      push1_pc_i;
   logic                     push2_valid_i;
   logic [INSTR_WIDTH-1:0]   push2_instr_i;
   logic [PC_WIDTH-1:0]      push2_pc_i;
   logic                     push_ready_o;
   logic                     dec_stall_i;
   logic [INSTR_WIDTH-1:0]   instruction1_o;
   logic                     ins1_valid_o;
   logic [PC_WIDTH-1:0]      PC1_o;
   logic [INSTR_WIDTH-1:0]   instruction2_o;
   logic                     ins2_valid_o;
   logic [PC_WIDTH-1:0]      PC2_o;
   logic [$clog2(DEPTH):0]   count_o;

   modport master (
      output flush_i, push1_valid_i, push1_instr_i, push1_pc_i,
             push2_valid_i, push2_instr_i, push2_pc_i, dec_stall_i,
      input  push_ready_o, instruction1_o, ins1_valid_o, PC1_o,
             instruction2_o, ins2_valid_o, PC2_o, count_o
   );

   modport slave (
      input  flush_i, push1_valid_i, push1_instr_i, push1_pc_i,
             push2_valid_i, push2_instr_i, push2_pc_i, dec_stall_i,
      output push_ready_o, instruction1_o, ins1_valid_o, PC1_o,
             instruction2_o, ins2_valid_o, PC2_o, count_o
   );

endinterface

`default_nettype wire

// File: rtl/fetch_queue_ptr.sv
// +------------------------------------------------------------------+
// | fq_ptr : wrap-bit pointer with synchronous clear, +0/+1/+2 step   |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module fq_ptr #(
   parameter int PTR_W = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             clr_i,
   input  wire logic [1:0]       inc_i,
   output logic      [PTR_W-1:0] ptr_o
);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q + PTR_W'(inc_i);
      if (clr_i) begin
         ptr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// +------------------------------------------------------------------+
// | fetch_queue : dual-push / dual-pop instruction buffer between     |
// |               fetch and decode. Optional FQ_BYPASS_EN macro lets  |
// |               pushes into an empty queue reach decode same cycle. |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_queue #(
   parameter int INSTR_WIDTH = 32,
   parameter int PC_WIDTH    = 32,
   parameter int DEPTH       = 8
) (
   input  wire logic clk,
   input  wire logic rst_n,
   fetch_queue_if.slave bus
);
   import core_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   head_ptr;
   logic [AW:0]   tail_ptr;
   logic [AW:0]   count;
   logic [1:0]    head_inc;
   logic [1:0]    tail_inc;
   logic          push_ready;
   logic          accept;
   logic          bypass;
   logic          v1;
   logic          v2;
   logic [AW-1:0] head_idx;
   logic [AW-1:0] head_idx2;
   logic [AW-1:0] tail_idx;
   fq_entry_t     push1_e;
   fq_entry_t     push2_e;
   fq_entry_t     out1;
   fq_entry_t     out2;
   logic          wr0_en;
   logic          wr1_en;
   logic [AW-1:0] wr0_idx;
   logic [AW-1:0] wr1_idx;
   fq_entry_t     wr0_data;
   fq_entry_t     wr1_data;

   fq_entry_t     mem_q [DEPTH];

   assign count      = tail_ptr - head_ptr;
   assign push_ready = (count <= (AW+1)'(DEPTH - 2));
   assign push1_e    = '{instr: bus.push1_instr_i, pc: bus.push1_pc_i};
   assign push2_e    = '{instr: bus.push2_instr_i, pc: bus.push2_pc_i};
   assign head_idx   = head_ptr[AW-1:0];
   assign head_idx2  = head_idx + 1'b1;
   assign tail_idx   = tail_ptr[AW-1:0];

   always_comb begin
      accept = push_ready & ~bus.flush_i & (bus.push1_valid_i | bus.push2_valid_i);
`ifdef FQ_BYPASS_EN
      bypass = (count == '0) & ~bus.dec_stall_i & ~bus.flush_i;
`else
      bypass = 1'b0;
`endif
      v1       = 1'b0;
      v2       = 1'b0;
      out1     = '0;
      out2     = '0;
      head_inc = 2'd0;
      tail_inc = 2'd0;
      wr0_en   = 1'b0;
      wr1_en   = 1'b0;
      wr0_idx  = tail_idx;
      wr1_idx  = tail_idx + 1'b1;
      wr0_data = bus.push1_valid_i ? push1_e : push2_e;
      wr1_data = push2_e;

      if (bypass) begin
         // Empty and unstalled: pushes go straight to decode, compacted to slot1.
         v1   = bus.push1_valid_i | bus.push2_valid_i;
         v2   = bus.push1_valid_i & bus.push2_valid_i;
         out1 = bus.push1_valid_i ? push1_e : push2_e;
         out2 = push2_e;
      end else begin
         v1       = (count >= (AW+1)'(1)) & ~bus.dec_stall_i & ~bus.flush_i;
         v2       = (count >= (AW+1)'(2)) & ~bus.dec_stall_i & ~bus.flush_i;
         out1     = mem_q[head_idx];
         out2     = mem_q[head_idx2];
         head_inc = pop_count(v1, v2);
         if (accept) begin
            wr0_en   = rst_n;
            wr1_en   = rst_n & bus.push1_valid_i & bus.push2_valid_i;
            tail_inc = pop_count(bus.push1_valid_i, bus.push2_valid_i);
         end
      end

      if (!v1) begin
         out1 = '0;
      end
      if (!v2) begin
         out2 = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr0_en) begin
         mem_q[wr0_idx] <= wr0_data;
      end
      if (wr1_en) begin
         mem_q[wr1_idx] <= wr1_data;
      end
   end

   fq_ptr #(.PTR_W(AW + 1)) u_head (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (bus.flush_i),
      .inc_i (head_inc),
      .ptr_o (head_ptr)
   );

   fq_ptr #(.PTR_W(AW + 1)) u_tail (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (bus.flush_i),
      .inc_i (tail_inc),
      .ptr_o (tail_ptr)
   );

   assign bus.push_ready_o   = push_ready;
   assign bus.count_o        = count;
   assign bus.ins1_valid_o   = v1;
   assign bus.ins2_valid_o   = v2;
   assign bus.instruction1_o = out1.instr;
   assign bus.PC1_o          = out1.pc;
   assign bus.instruction2_o = out2.instr;
   assign bus.PC2_o          = out2.pc;

`ifndef SYNTHESIS
   // Fetch must not push while the queue reports fewer than two free entries.
   a_push_when_ready : assert property (@(posedge clk) disable iff (!rst_n)
      (push_ready || bus.flush_i || !(bus.push1_valid_i || bus.push2_valid_i)))
      else $warning("fetch_queue: push while not ready dropped");
`endif

endmodule

`default_nettype wire
